mbist_march_engine: RTL and testbench

// - MBIST initiator: runs March C- on an SRAM via its cs/we/re/addr/wdata/rdata port, compares every read.
// - Sits between the MBIST controller top (start/status) and sram_wrapper (memory-side responder).
// - Reports pass/fail, first-failing address, March element and read data.

---
 rtl/mbist_pkg.sv | 41 ++++
 rtl/mbist_addr_gen.sv | 46 ++++
 rtl/mbist_march_engine.sv | 211 +++++++++++++++++++++
 tb/tb_mbist_march_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST March engine.
package mbist_pkg;

    localparam int MARCH_NUM_ELEM = 6;

    typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} march_elem_t;
    typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    typedef struct packed {
        op_t        op0;
        op_t        op1;
        logic [1:0] op_cnt;
        logic       down;
    } elem_desc_t;

    // March C-: {w0} up, (r0,w1) up, (r1,w0) up, (r0,w1) down, (r1,w0) down, (r0) up
    function automatic elem_desc_t elem_desc(input march_elem_t e);
        elem_desc_t d;
        d = '{OP_W0, OP_W0, 2'd1, 1'b0};
        case (e)
            E0:      d = '{OP_W0, OP_W0, 2'd1, 1'b0};
            E1:      d = '{OP_R0, OP_W1, 2'd2, 1'b0};
            E2:      d = '{OP_R1, OP_W0, 2'd2, 1'b0};
            E3:      d = '{OP_R0, OP_W1, 2'd2, 1'b1};
            E4:      d = '{OP_R1, OP_W0, 2'd2, 1'b1};
            E5:      d = '{OP_R0, OP_R0, 2'd1, 1'b0};
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic op_is_read(input op_t op);
        return (op == OP_R0) || (op == OP_R1);
    endfunction

    function automatic logic op_data_one(input op_t op);
        return (op == OP_W1) || (op == OP_R1);
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for the March engine: loads the element's start
// address, steps once per address and flags the last address of the sweep.
module mbist_addr_gen
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_i,
    input  logic                  load_down_i,
    input  logic                  step_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  is_last_o
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  down_q, down_d;

    always_comb begin
        addr_d = addr_q;
        down_d = down_q;
        if (load_i) begin
            down_d = load_down_i;
            addr_d = load_down_i ? '1 : '0;
        end else if (step_i) begin
            addr_d = down_q ? addr_q - ONE : addr_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            down_q <= down_d;
        end
    end

    assign addr_o    = addr_q;
    assign is_last_o = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/mbist_march_engine.sv
// MBIST initiator: runs March C- on an SRAM port and compares every read.
// MBIST_CONTINUE_ON_FAIL_EN: run to completion on mismatch, count failing reads on fail_count.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// ISSUE   | one memory op on the port (write completes here, read starts)
// WAIT    | read latency; compare on the last wait cycle
// DONE    | result held until start or reset
// The advance step (next op / address / element) is folded into the last
// cycle of ISSUE or WAIT so ops run back to back.
module mbist_march_engine
    import mbist_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [2:0]            fail_element,
    output logic [DATA_WIDTH-1:0] fail_rdata,
`ifdef MBIST_CONTINUE_ON_FAIL_EN
    output logic [15:0]           fail_count,
`endif
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [WCW-1:0] WAIT_LOAD = WCW'(READ_LATENCY - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    state_t                state_q, state_d;
    march_elem_t           elem_q, elem_d, next_elem;
    logic                  op_idx_q, op_idx_d;
    logic [WCW-1:0]        wait_cnt_q, wait_cnt_d;
    logic                  fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]            fail_elem_q, fail_elem_d;
    logic [DATA_WIDTH-1:0] fail_rdata_q, fail_rdata_d;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
    logic [15:0]           fail_cnt_q, fail_cnt_d;
`endif

    elem_desc_t            desc, next_desc;
    op_t                   op;
    logic [DATA_WIDTH-1:0] op_data;
    logic                  advance;
    logic                  ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_WIDTH-1:0] ag_addr;

    assign desc      = elem_desc(elem_q);
    assign next_elem = march_elem_t'(elem_q + 3'd1);
    assign next_desc = elem_desc(next_elem);
    assign op        = op_idx_q ? desc.op1 : desc.op0;
    assign op_data   = {DATA_WIDTH{op_data_one(op)}};

    mbist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ag_load),
        .load_down_i (ag_load_down),
        .step_i      (ag_step),
        .addr_o      (ag_addr),
        .is_last_o   (ag_last)
    );

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        op_idx_d     = op_idx_q;
        wait_cnt_d   = wait_cnt_q;
        fail_d       = fail_q;
        fail_addr_d  = fail_addr_q;
        fail_elem_d  = fail_elem_q;
        fail_rdata_d = fail_rdata_q;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
        fail_cnt_d   = fail_cnt_q;
`endif
        advance      = 1'b0;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_wdata    = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_ISSUE;
                    elem_d       = E0;
                    op_idx_d     = 1'b0;
                    fail_d       = 1'b0;
                    fail_addr_d  = '0;
                    fail_elem_d  = '0;
                    fail_rdata_d = '0;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
                    fail_cnt_d   = '0;
`endif
                    ag_load      = 1'b1;
                end
            end
            S_ISSUE: begin
                mem_cs = 1'b1;
                if (op_is_read(op)) begin
                    mem_re     = 1'b1;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = S_WAIT;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = op_data;
                    advance   = 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - WAIT_ONE;
                end else begin
                    advance = 1'b1;
                    if (mem_rdata != op_data) begin
                        fail_d = 1'b1;
                        if (!fail_q) begin
                            fail_addr_d  = ag_addr;
                            fail_elem_d  = elem_q;
                            fail_rdata_d = mem_rdata;
                        end
`ifdef MBIST_CONTINUE_ON_FAIL_EN
                        if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
`else
                        advance = 1'b0;
                        state_d = S_DONE;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Second op at the same address, else next address, else next element.
        if (advance) begin
            state_d = S_ISSUE;
            if (!op_idx_q && (desc.op_cnt == 2'd2)) begin
                op_idx_d = 1'b1;
            end else begin
                op_idx_d = 1'b0;
                if (!ag_last) begin
                    ag_step = 1'b1;
                end else if (elem_q == E5) begin
                    state_d = S_DONE;
                end else begin
                    elem_d       = next_elem;
                    ag_load      = 1'b1;
                    ag_load_down = next_desc.down;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            elem_q       <= E0;
            op_idx_q     <= 1'b0;
            wait_cnt_q   <= '0;
            fail_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_elem_q  <= '0;
            fail_rdata_q <= '0;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
            fail_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            elem_q       <= elem_d;
            op_idx_q     <= op_idx_d;
            wait_cnt_q   <= wait_cnt_d;
            fail_q       <= fail_d;
            fail_addr_q  <= fail_addr_d;
            fail_elem_q  <= fail_elem_d;
            fail_rdata_q <= fail_rdata_d;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
            fail_cnt_q   <= fail_cnt_d;
`endif
        end
    end

    assign mem_addr     = mem_cs ? ag_addr : '0;
    assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done         = (state_q == S_DONE);
    assign pass         = done & ~fail_q;
    assign fail         = fail_q;
    assign fail_addr    = fail_addr_q;
    assign fail_element = fail_elem_q;
    assign fail_rdata   = fail_rdata_q;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
    assign fail_count   = fail_cnt_q;
`endif

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: SRAM model with stuck-at injection, March C- reference
// model feeding an op/result scoreboard, reset and start-handling scenarios.
`timescale 1ns/1ps
module tb_mbist_march_engine;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RL = 1;
    localparam int N  = 1 << AW;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    // op codes: 0=w0 1=w1 2=r0 3=r1, -1 = none
    localparam int ELEM_OPS [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};
    localparam bit ELEM_DOWN [6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    typedef struct packed {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_op_t;

    typedef struct {
        int            cycles;
        bit            fail;
        logic [AW-1:0] addr;
        logic [2:0]    elem;
        logic [DW-1:0] rdata;
        int            nfail;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, pass, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_element;
    logic [DW-1:0] fail_rdata;
`ifdef MBIST_CONTINUE_ON_FAIL_EN
    logic [15:0]   fail_count;
`endif
    logic          mem_cs, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    exp_op_t op_q[$];
    exp_t    exp_q[$];

    always #5 clk = ~clk;

    mbist_march_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .fail_addr    (fail_addr),
        .fail_element (fail_element),
        .fail_rdata   (fail_rdata),
`ifdef MBIST_CONTINUE_ON_FAIL_EN
        .fail_count   (fail_count),
`endif
        .mem_cs       (mem_cs),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    // SRAM with an optional stuck value at one address
    logic [DW-1:0] mem [N];
    logic [DW-1:0] rd_pipe [RL];
    bit            fault_en = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic [DW-1:0] fault_val = '0;

    always @(posedge clk) begin
        if (mem_cs && mem_we)
            mem[mem_addr] <= (fault_en && mem_addr == fault_addr) ? fault_val : mem_wdata;
        if (mem_cs && mem_re)
            rd_pipe[0] <= mem[mem_addr];
        for (int i = 1; i < RL; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RL-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: walk March C- over an array, recording the op stream and first failure.
    task automatic build_expect(input bit fen, input logic [AW-1:0] fa,
                                input logic [DW-1:0] fv, output int cycles);
        logic [DW-1:0] m [N];
        exp_t r;
        bit stop;
        r = '{cycles: 0, fail: 1'b0, addr: '0, elem: '0, rdata: '0, nfail: 0};
        stop = 1'b0;
        for (int e = 0; e < 6 && !stop; e++) begin
            for (int k = 0; k < N && !stop; k++) begin
                int a;
                a = ELEM_DOWN[e] ? (N - 1 - k) : k;
                for (int j = 0; j < 2 && !stop; j++) begin
                    int code;
                    logic [DW-1:0] val;
                    logic [DW-1:0] rd;
                    code = ELEM_OPS[e][j];
                    val  = (code % 2 == 1) ? '1 : '0;
                    if (code >= 2) begin
                        op_q.push_back('{1'b0, 1'b1, AW'(a), '0});
                        r.cycles += 1 + RL;
                        rd = m[a];
                        if (rd !== val) begin
                            r.nfail++;
                            if (!r.fail) begin
                                r.fail  = 1'b1;
                                r.addr  = AW'(a);
                                r.elem  = 3'(e);
                                r.rdata = rd;
                            end
                            if (!CONT) stop = 1'b1;
                        end
                    end else if (code >= 0) begin
                        op_q.push_back('{1'b1, 1'b0, AW'(a), val});
                        r.cycles += 1;
                        m[a] = (fen && AW'(a) == fa) ? fv : val;
                    end
                end
            end
        end
        exp_q.push_back(r);
        cycles = r.cycles;
    endtask

    // Monitor: op stream and protocol every cycle, result compare when done rises.
    int busy_cyc = 0;
    int op_errs = 0;
    int proto_errs = 0;
    bit done_prev = 1'b0;

    always @(negedge clk) begin
        exp_op_t eo;
        exp_t    r;
        if (reset) begin
            busy_cyc = 0; op_errs = 0; proto_errs = 0; done_prev = 1'b0;
            op_q.delete(); exp_q.delete();
        end else begin
            if (busy) busy_cyc++;
            if (mem_cs && mem_we && mem_re) proto_errs++;
            if (!mem_cs && (mem_we || mem_re)) proto_errs++;
            if (!mem_we && mem_wdata != '0) proto_errs++;
            if (mem_cs) begin
                if (op_q.size() == 0) op_errs++;
                else begin
                    eo = op_q.pop_front();
                    if ({mem_we, mem_re, mem_addr, mem_wdata} !== eo) op_errs++;
                end
            end
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    r = exp_q.pop_front();
                    check("op_cycles", 64'(busy_cyc), 64'(r.cycles));
                    check("pass", 64'(pass), 64'(!r.fail));
                    check("fail", 64'(fail), 64'(r.fail));
                    check("fail_addr", 64'(fail_addr), 64'(r.addr));
                    check("fail_element", 64'(fail_element), 64'(r.elem));
                    check("fail_rdata", 64'(fail_rdata), 64'(r.rdata));
`ifdef MBIST_CONTINUE_ON_FAIL_EN
                    check("fail_count", 64'(fail_count), 64'((r.nfail > 65535) ? 65535 : r.nfail));
`endif
                    check("ops_missing", 64'(op_q.size()), 64'd0);
                    check("op_trace_errs", 64'(op_errs), 64'd0);
                    check("protocol_errs", 64'(proto_errs), 64'd0);
                end
                busy_cyc = 0; op_errs = 0; proto_errs = 0;
                op_q.delete();
            end
            done_prev = done;
        end
    end

    task automatic pulse_start(input bit fen, input logic [AW-1:0] fa,
                               input logic [DW-1:0] fv, output int cycles);
        @(posedge clk); #1;
        fault_en = fen; fault_addr = fa; fault_val = fv;
        build_expect(fen, fa, fv, cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_test(input bit fen, input logic [AW-1:0] fa,
                            input logic [DW-1:0] fv, input bit repulse);
        int  cycles;
        bit  seen;
        pulse_start(fen, fa, fv, cycles);
        @(negedge clk);
        check("busy_after_start", 64'(busy), 64'd1);
        check("status_cleared_on_start",
              64'({done, pass, fail, fail_addr, fail_element, fail_rdata}), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < cycles + 10; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            start = repulse && ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic reset_in_e3();
        int cycles;
        int k;
        pulse_start(1'b0, '0, '0, cycles);
        k = 7 * N + $urandom_range(0, 3 * N - 1);
        repeat (k) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mem_port", 64'({mem_cs, mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
        check("rst_status", 64'({done, pass, fail, fail_addr, fail_element, fail_rdata}), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_status", 64'({busy, done, pass, fail, fail_addr, fail_element, fail_rdata}), 64'd0);
        check("reset_mem_port", 64'({mem_cs, mem_we, mem_re, mem_addr, mem_wdata}), 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        run_test(1'b0, '0, '0, 1'b0);
        run_test(1'b1, AW'(5), '0, 1'b0);
        run_test(1'b0, '0, '0, 1'b1);
        reset_in_e3();
        run_test(1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] fv;
            case ($urandom_range(0, 2))
                0:       fv = '0;
                1:       fv = '1;
                default: fv = DW'($urandom);
            endcase
            run_test(i != 3, AW'($urandom_range(0, N - 1)), fv, i[0]);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
